// File: rtl/montgomery_multiplier.sv
// rtl/montgomery_multiplier.sv - bit-serial radix-2 Montgomery multiplier, result = A*B*2^-N mod M
// One LOOP cycle per bit of A, then a single conditional subtract to land in [0, M).
module montgomery_multiplier #(
  parameter int N = 1024
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOOP,
    SUB,
    DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [N-1:0]    m_q;
  logic [N+1:0]    c_q;
  logic [IW-1:0]   i_q;

  logic [N+1:0]    c1;
  logic [N+1:0]    c2;
  logic            c_ge_m;
  logic [N-1:0]    c_minus_m;

  // C stays below 2M, so C + B + M < 4M and never overflows N+2 bits.
  always_comb begin
    c1 = c_q + (a_q[0] ? {2'b00, b_q} : '0);
    c2 = c1 + (c1[0] ? {2'b00, m_q} : '0);
  end

  // C < 2M makes C - M < M, so the low N bits of the modular difference are exact.
  always_comb begin
    c_ge_m    = (c_q >= {2'b00, m_q});
    c_minus_m = c_q[N-1:0] - m_q;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOOP;
      LOOP:    if (i_q == LAST) state_next = SUB;
      SUB:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      c_q    <= '0;
      i_q    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= in_a;
            b_q <= in_b;
            m_q <= in_m;
            c_q <= '0;
            i_q <= '0;
          end
        end
        LOOP: begin
          c_q <= c2 >> 1;
          a_q <= a_q >> 1;
          i_q <= i_q + 1'b1;
        end
        SUB: begin
          result <= c_ge_m ? c_minus_m : c_q[N-1:0];
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_multiplier.sv
// tb/tb_montgomery_multiplier.sv - self-checking bench for montgomery_multiplier
// Reference: (A*B mod M) halved modulo M N times, i.e. multiplied by 2^-N.
module tb_montgomery_multiplier;

  localparam int N   = 1024;
  localparam int LAT = N + 2;
  localparam int NV  = 8;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_m;
  logic [N-1:0] result;
  logic         done;

  int checks = 0;
  int errors = 0;
  int cyc;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] m;
    logic [N-1:0] exp;
  } vec_t;

  vec_t vecs [NV];

  montgomery_multiplier #(.N(N)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .in_a   (in_a),
    .in_b   (in_b),
    .in_m   (in_m),
    .result (result),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] rand_wide();
    logic [N-1:0] v;
    v = '0;
    for (int k = 0; k < N / 32; k++) v = {v[N-33:0], 32'($urandom)};
    return v;
  endfunction

  function automatic logic [N-1:0] mont_ref(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [N-1:0] m);
    logic [2*N-1:0] p;
    logic [N:0]     x;
    p = ({{N{1'b0}}, a} * {{N{1'b0}}, b}) % {{N{1'b0}}, m};
    x = (N + 1)'(p);
    for (int k = 0; k < N; k++) x = x[0] ? (x + {1'b0, m}) >> 1 : x >> 1;
    return N'(x);
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    logic [127:0] act_lo;
    logic [127:0] exp_lo;
    checks++;
    if (act !== exp) begin
      errors++;
      act_lo = act[127:0];
      exp_lo = exp[127:0];
      $display("FAIL %s: got (low 128 bits) %h, expected %h", name, act_lo, exp_lo);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive start for 'hold' cycles, then scramble the operand inputs.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] m, input int hold);
    @(negedge clk);
    in_a  = a;
    in_b  = b;
    in_m  = m;
    start = 1'b1;
    cyc   = 0;
    repeat (hold) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    in_a  = rand_wide();
    in_b  = rand_wide();
    in_m  = rand_wide();
  endtask

  task automatic advance_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_done(output int lat);
    while (!done && cyc < LAT + 200) begin
      @(negedge clk);
      cyc++;
    end
    lat = done ? cyc : -1;
  endtask

  task automatic rand_vec(output vec_t v);
    v.m   = rand_wide() | {1'b1, {(N - 2){1'b0}}, 1'b1};
    v.a   = rand_wide() % v.m;
    v.b   = rand_wide() % v.m;
    v.exp = mont_ref(v.a, v.b, v.m);
  endtask

  initial begin
    logic [N-1:0] mneg1;
    logic [N-1:0] res1;
    vec_t         v;
    vec_t         w;
    int           lat;
    int           dones;

    mneg1  = '1;
    resetn = 1'b0;
    start  = 1'b0;
    in_a   = '0;
    in_b   = '0;
    in_m   = '0;

    vecs[0] = '{a: N'(1), b: N'(5), m: mneg1, exp: N'(5)};
    vecs[1] = '{a: mneg1 - 1, b: mneg1 - 1, m: mneg1, exp: N'(1)};
    rand_vec(vecs[2]);
    vecs[2].a   = '0;
    vecs[2].exp = '0;
    vecs[3].a = 1024'hb4d6d951f6532ac13ec6a44addbb552b3eca8fef9a81a1fd095485063c7ee4f89dcf19acf884fa9d0b6ce9c148e6b85af88024189c1da60e534acc6c7969363b;
    vecs[3].b = 1024'h86eb6f8babc25f0986ba7460e46ffd91f34532c114485075f85ff900d4cf71d918be9ef170e1b84bca67755131efcbb767a2e069ad68c321a1cb985909098399;
    vecs[3].m = 1024'hfe93fee7fd5d369339166e57cf5f773c1698c44b91a9f9a4be462bee6a82552d982845cd2787e90bc0245b4e781b9e1be10c615e2c814b3d85b78e358fa2c393;
    vecs[3].exp = mont_ref(vecs[3].a, vecs[3].b, vecs[3].m);
    for (int k = 4; k < NV; k++) rand_vec(vecs[k]);

    repeat (3) @(negedge clk);
    check("reset_done", {{(N - 1){1'b0}}, done}, '0);
    check("reset_result", result, '0);
    resetn = 1'b1;

    for (int k = 0; k < NV; k++) begin
      start_op(vecs[k].a, vecs[k].b, vecs[k].m, 1);
      wait_done(lat);
      check($sformatf("vec%0d_result", k), result, vecs[k].exp);
      check_int($sformatf("vec%0d_latency", k), lat, LAT);
    end

    // Second start at cycle 100 must not disturb the running operation.
    rand_vec(v);
    start_op(v.a, v.b, v.m, 1);
    advance_to(100);
    in_a  = rand_wide();
    start = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    wait_done(lat);
    check("busy_start_result", result, v.exp);
    check_int("busy_start_latency", lat, LAT);

    // Start held for several cycles counts once.
    rand_vec(v);
    start_op(v.a, v.b, v.m, 4);
    wait_done(lat);
    check("held_start_result", result, v.exp);
    check_int("held_start_latency", lat, LAT);

    // A start seen in the DONE cycle is ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    repeat (LAT + 50) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_int("done_cycle_start_ignored", dones, 0);
    check("done_cycle_start_result", result, v.exp);

    // Reset mid-operation clears outputs at once.
    rand_vec(v);
    start_op(v.a, v.b, v.m, 1);
    advance_to(500);
    resetn = 1'b0;
    #1;
    check("abort_done", {{(N - 1){1'b0}}, done}, '0);
    check("abort_result", result, '0);
    @(negedge clk);
    resetn = 1'b1;
    dones = 0;
    repeat (LAT) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_int("abort_no_done", dones, 0);
    rand_vec(v);
    start_op(v.a, v.b, v.m, 1);
    wait_done(lat);
    check("after_reset_result", result, v.exp);
    check_int("after_reset_latency", lat, LAT);

    // Back-to-back: second start in the cycle after done.
    rand_vec(v);
    rand_vec(w);
    start_op(v.a, v.b, v.m, 1);
    wait_done(lat);
    res1 = result;
    check("b2b_first_result", res1, v.exp);
    start_op(w.a, w.b, w.m, 1);
    check("b2b_stable_early", result, v.exp);
    advance_to(LAT - 1);
    check("b2b_stable_sub", result, v.exp);
    wait_done(lat);
    check("b2b_second_result", result, w.exp);
    check_int("b2b_second_latency", lat, LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
